// File: rtl/abuf_drain.sv
// Drains words from the PE accumulation buffer, rounds, shifts and saturates
// each lane, and queues the results in a 4-deep first-word-fall-through FIFO.
package GLOBAL_PARAM;
   localparam int BATCH  = 4;
   localparam int RES_W  = 32;
   localparam int DATA_W = 8;
endpackage

module abuf_drain #(
   parameter int BATCH     = GLOBAL_PARAM::BATCH,
   parameter int RES_W     = GLOBAL_PARAM::RES_W,
   parameter int DATA_W    = GLOBAL_PARAM::DATA_W,
   parameter int BUF_DEPTH = 256,
   localparam int ADDR_W   = $clog2(BUF_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W:0]           len,
   input  logic [4:0]                shift,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W-1:0]         abuf_rd_addr,
   input  logic [BATCH*RES_W-1:0]    abuf_rd_data,
   output logic [BATCH*DATA_W-1:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam logic [ADDR_W:0]       CNT_ONE = (ADDR_W+1)'(1);
   localparam logic signed [RES_W:0] SAT_MAX = (RES_W+1)'(2**(DATA_W-1) - 1);
   localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;

   state_t                    state;
   logic [ADDR_W:0]           len_q;
   logic [ADDR_W:0]           rd_cnt;
   logic [ADDR_W:0]           xfer_cnt;
   logic [4:0]                shift_q;
   logic                      rd_v0;
   logic                      rd_v1;
   logic                      credit_ok;
   logic                      push;
   logic                      pop;
   logic [BATCH*DATA_W-1:0]   q_word;
   logic [BATCH*DATA_W-1:0]   fifo_mem [4];
   logic [1:0]                wr_ptr;
   logic [1:0]                rd_ptr;
   logic [2:0]                fifo_cnt;

   // Round half up, arithmetic shift and clamp, all in RES_W+1 bits so the
   // rounding add can never wrap.
   function automatic logic [DATA_W-1:0] quant_lane(input logic [RES_W-1:0] x,
                                                    input logic [4:0]       sh);
      logic signed [RES_W:0] acc;
      logic signed [RES_W:0] rnd;
      acc = $signed({x[RES_W-1], x});
      rnd = '0;
      if (sh != 5'd0) rnd = (RES_W+1)'(1) << (sh - 5'd1);
      acc = (acc + rnd) >>> sh;
      if (acc > SAT_MAX) return SAT_MAX[DATA_W-1:0];
      else if (acc < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      return acc[DATA_W-1:0];
   endfunction

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      q_word = '0;
      for (int i = 0; i < BATCH; i++)
         q_word[i*DATA_W +: DATA_W] = quant_lane(abuf_rd_data[i*RES_W +: RES_W], shift_q);
   end

   // Reads in flight plus words already queued may never exceed the FIFO depth.
   assign credit_ok = ({2'b00, rd_v0} + {2'b00, rd_v1} + fifo_cnt) < 3'd4;
   assign push      = rd_v1;
   assign out_valid = (fifo_cnt != 3'd0);
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         abuf_rd_addr <= '0;
         len_q        <= '0;
         shift_q      <= '0;
         rd_cnt       <= '0;
         xfer_cnt     <= '0;
         rd_v0        <= 1'b0;
         rd_v1        <= 1'b0;
      end else begin
         done  <= 1'b0;
         rd_v0 <= 1'b0;
         rd_v1 <= rd_v0;
         if (pop) xfer_cnt <= xfer_cnt + CNT_ONE;
         case (state)
            IDLE: begin
               if (start && !busy) begin
                  busy     <= 1'b1;
                  len_q    <= len;
                  shift_q  <= shift;
                  rd_cnt   <= '0;
                  xfer_cnt <= '0;
                  if (len == '0) done  <= 1'b1;
                  else           state <= RUN;
               end else begin
                  busy <= 1'b0;
               end
            end
            RUN: begin
               if (credit_ok) begin
                  abuf_rd_addr <= rd_cnt[ADDR_W-1:0];
                  rd_v0        <= 1'b1;
                  rd_cnt       <= rd_cnt + CNT_ONE;
                  if (rd_cnt + CNT_ONE == len_q) state <= FLUSH;
               end
            end
            FLUSH: begin
               // busy stays high through the done cycle and drops in IDLE
               if (pop && (xfer_cnt + CNT_ONE == len_q)) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; pointers and count define validity and
   // out_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= q_word;
   end

endmodule

// File: tb/tb_abuf_drain.sv
// Directed bench for abuf_drain: behavioural buffer RAM, transfer monitor and
// one task per scenario with hand-computed expectations.
module tb_abuf_drain;

   localparam int BATCH  = GLOBAL_PARAM::BATCH;
   localparam int RES_W  = GLOBAL_PARAM::RES_W;
   localparam int DATA_W = GLOBAL_PARAM::DATA_W;
   localparam int ADDR_W = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [ADDR_W:0]         len;
   logic [4:0]              shift;
   logic                    busy;
   logic                    done;
   logic [ADDR_W-1:0]       abuf_rd_addr;
   logic [BATCH*RES_W-1:0]  abuf_rd_data;
   logic [BATCH*DATA_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;

   logic [BATCH*RES_W-1:0]  mem [256];
   logic [BATCH*DATA_W-1:0] got [$];
   int                      done_cnt = 0;
   int                      hold_err = 0;
   logic                    prev_stall = 1'b0;
   logic [BATCH*DATA_W-1:0] prev_data = '0;
   int                      n_checks = 0;
   int                      n_fail = 0;

   abuf_drain dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .shift        (shift),
      .busy         (busy),
      .done         (done),
      .abuf_rd_addr (abuf_rd_addr),
      .abuf_rd_data (abuf_rd_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) abuf_rd_data <= mem[abuf_rd_addr];

   // Transfer/done recorder plus hold-stable watcher for stalled outputs.
   always @(negedge clk) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) done_cnt <= done_cnt + 1;
      if (!rst && prev_stall && (!out_valid || out_data !== prev_data)) hold_err <= hold_err + 1;
      prev_stall <= !rst && out_valid && !out_ready;
      prev_data  <= out_data;
   end

   function automatic logic [BATCH*RES_W-1:0] mkw(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [BATCH*DATA_W-1:0] exp8(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic pulse_start(input int n, input int sh);
      @(posedge clk); #1;
      start = 1'b1;
      len   = (ADDR_W+1)'(n);
      shift = 5'(sh);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain(input int dbase, input int mode, input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (done_cnt != dbase) begin
            timed_out = 1'b0;
            break;
         end
         out_ready = (mode == 0) || (c % 2 == 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; len = 9'd5; shift = 5'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (abuf_rd_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 00", abuf_rd_addr); end
      n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_with_rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int                      addr_exp [10];
      logic [BATCH*DATA_W-1:0] data_exp [4];
      addr_exp = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3};
      data_exp = '{32'h9C64FD05, 32'h64FD059C, 32'hFD059C64, 32'h059C64FD};
      mem[0] = mkw(5, -3, 100, -100);
      mem[1] = mkw(-100, 5, -3, 100);
      mem[2] = mkw(100, -100, 5, -3);
      mem[3] = mkw(-3, 100, -100, 5);
      out_ready = 1'b1;
      pulse_start(4, 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++; if (abuf_rd_addr !== ADDR_W'(addr_exp[c])) begin n_fail++; $display("FAIL basic_addr c%0d: got %0d want %0d", c, abuf_rd_addr, addr_exp[c]); end
         n_checks++; if (out_valid !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL basic_valid c%0d: got %b", c, out_valid); end
         n_checks++; if (done !== (c == 7)) begin n_fail++; $display("FAIL basic_done c%0d: got %b", c, done); end
         n_checks++; if (busy !== (c <= 7)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b", c, busy); end
         if (c >= 3 && c <= 6) begin
            n_checks++; if (out_data !== data_exp[c-3]) begin n_fail++; $display("FAIL basic_data c%0d: got %h want %h", c, out_data, data_exp[c-3]); end
         end
      end
   endtask

   task automatic test_len_zero();
      pulse_start(0, 0);
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len0_busy: got %b want 1", busy); end
      n_checks++; if (abuf_rd_addr !== 8'd3) begin n_fail++; $display("FAIL len0_addr: got %0d want 3", abuf_rd_addr); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_end: got %b want 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy_end: got %b want 0", busy); end
      n_checks++; if (abuf_rd_addr !== 8'd3) begin n_fail++; $display("FAIL len0_addr_end: got %0d want 3", abuf_rd_addr); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_shift();
      int                      pn [4];
      int                      psh [4];
      logic [BATCH*RES_W-1:0]  pm0 [4];
      logic [BATCH*DATA_W-1:0] pe0 [4];
      logic [BATCH*DATA_W-1:0] w;
      int                      base;
      int                      dbase;
      bit                      to;
      pn  = '{2, 1, 1, 1};
      psh = '{4, 0, 1, 31};
      pm0[0] = mkw(24, 23, -24, 40000);               pe0[0] = 32'h7FFF0102;
      pm0[1] = mkw(200, -200, 127, -128);             pe0[1] = 32'h807F807F;
      pm0[2] = mkw(3, -3, 1, -1);                     pe0[2] = 32'h0001FF02;
      pm0[3] = mkw(2147483647, 32'h80000000, 1073741824, -1); pe0[3] = 32'h0001FF01;
      out_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         mem[0] = pm0[p];
         mem[1] = mkw(-40000, 8, -8, 7);
         base  = got.size();
         dbase = done_cnt;
         pulse_start(pn[p], psh[p]);
         drain(dbase, 0, 100, to);
         n_checks++; if (to) begin n_fail++; $display("FAIL shift_timeout p%0d: no done", p); end
         n_checks++; if (got.size() - base != pn[p]) begin n_fail++; $display("FAIL shift_count p%0d: got %0d want %0d", p, got.size() - base, pn[p]); end
         w = (got.size() > base) ? got[base] : 'x;
         n_checks++; if (w !== pe0[p]) begin n_fail++; $display("FAIL shift_word0 p%0d: got %h want %h", p, w, pe0[p]); end
         if (pn[p] > 1) begin
            w = (got.size() > base + 1) ? got[base+1] : 'x;
            n_checks++; if (w !== 32'h00000180) begin n_fail++; $display("FAIL shift_word1 p%0d: got %h want 00000180", p, w); end
         end
      end
   endtask

   task automatic test_credit();
      logic [BATCH*DATA_W-1:0] w;
      int                      base;
      int                      dbase;
      int                      hbase;
      bit                      to;
      for (int k = 0; k < 16; k++) mem[k] = mkw(k, -k, 7*k, k-8);
      out_ready = 1'b0;
      base  = got.size();
      dbase = done_cnt;
      hbase = hold_err;
      pulse_start(16, 0);
      repeat (10) @(negedge clk);
      n_checks++; if (abuf_rd_addr !== 8'd3) begin n_fail++; $display("FAIL credit_stall_addr: got %0d want 3", abuf_rd_addr); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL credit_stall_valid: got %b want 1", out_valid); end
      n_checks++; if (out_data !== 32'hF8000000) begin n_fail++; $display("FAIL credit_stall_data: got %h want F8000000", out_data); end
      drain(dbase, 1, 300, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL credit_timeout: no done"); end
      n_checks++; if (got.size() - base != 16) begin n_fail++; $display("FAIL credit_count: got %0d want 16", got.size() - base); end
      for (int i = 0; i < 16; i++) begin
         w = (got.size() > base + i) ? got[base+i] : 'x;
         n_checks++; if (w !== exp8(i, -i, 7*i, i-8)) begin n_fail++; $display("FAIL credit_word%0d: got %h want %h", i, w, exp8(i, -i, 7*i, i-8)); end
      end
      n_checks++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL credit_done_count: got %0d want 1", done_cnt - dbase); end
      n_checks++; if (hold_err != hbase) begin n_fail++; $display("FAIL credit_hold: %0d unstable stall cycles, want 0", hold_err - hbase); end
   endtask

   task automatic test_start_busy();
      logic [BATCH*DATA_W-1:0] w;
      int                      base;
      int                      dbase;
      bit                      to;
      out_ready = 1'b1;
      base  = got.size();
      dbase = done_cnt;
      pulse_start(8, 0);
      @(posedge clk); #1;
      start = 1'b1; len = 9'd3;
      @(posedge clk); #1;
      start = 1'b0;
      drain(dbase, 0, 100, to);
      repeat (6) @(posedge clk);
      @(negedge clk);
      n_checks++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: no done"); end
      n_checks++; if (got.size() - base != 8) begin n_fail++; $display("FAIL busy_start_count: got %0d want 8", got.size() - base); end
      for (int i = 0; i < 8; i++) begin
         w = (got.size() > base + i) ? got[base+i] : 'x;
         n_checks++; if (w !== exp8(i, -i, 7*i, i-8)) begin n_fail++; $display("FAIL busy_start_word%0d: got %h want %h", i, w, exp8(i, -i, 7*i, i-8)); end
      end
      n_checks++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - dbase); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [BATCH*DATA_W-1:0] w;
      int                      base;
      int                      dbase;
      bit                      found;
      bit                      to;
      out_ready = 1'b1;
      base  = got.size();
      dbase = done_cnt;
      found = 1'b0;
      pulse_start(8, 0);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (got.size() - base >= 3) begin
            out_ready = 1'b0;
            rst       = 1'b1;
            found     = 1'b1;
            break;
         end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_wait: 3 transfers not seen"); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      repeat (6) @(negedge clk);
      n_checks++; if (done_cnt != dbase) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - dbase); end
      n_checks++; if (got.size() - base != 3) begin n_fail++; $display("FAIL rstmid_count: got %0d want 3", got.size() - base); end
      mem[0] = mkw(-7, 9, -11, 13);
      mem[1] = mkw(1, 2, 3, 4);
      out_ready = 1'b1;
      base  = got.size();
      dbase = done_cnt;
      pulse_start(2, 0);
      drain(dbase, 0, 100, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_restart_timeout: no done"); end
      n_checks++; if (got.size() - base != 2) begin n_fail++; $display("FAIL rstmid_restart_count: got %0d want 2", got.size() - base); end
      w = (got.size() > base) ? got[base] : 'x;
      n_checks++; if (w !== exp8(-7, 9, -11, 13)) begin n_fail++; $display("FAIL rstmid_word0: got %h want %h", w, exp8(-7, 9, -11, 13)); end
      w = (got.size() > base + 1) ? got[base+1] : 'x;
      n_checks++; if (w !== exp8(1, 2, 3, 4)) begin n_fail++; $display("FAIL rstmid_word1: got %h want %h", w, exp8(1, 2, 3, 4)); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_basic();
      test_len_zero();
      test_shift();
      test_credit();
      test_start_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
